// File: rtl/btn_pkg.sv
// ============================================================================
//  btn_pkg
//  Shared defaults and the per-channel debounce state encoding.
//  Rev 1.0
// ============================================================================
`default_nettype none

package btn_pkg;

   localparam int DEFAULT_STABLE_CYCLES = 4;
   localparam int DEFAULT_N_BTN         = 2;

   // Encoding is {btn_level, counter_nonzero}
   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      PRESS_PEND = 2'b01,
      HELD       = 2'b10,
      REL_PEND   = 2'b11
   } chan_state_t;

endpackage : btn_pkg

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
//  debounce_channel
//  One button: 2-flop synchroniser, stability counter, press/release pulses.
//  Rev 1.0
// ============================================================================
`default_nettype none

module debounce_channel
   import btn_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic press_next
);

   localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   chan_state_t      state;

   assign state = chan_state_t'({level_q, (cnt_q != '0)});

   // Any sample equal to the current level restarts qualification from zero.
   always_comb begin
      level_d   = level_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state)
         IDLE, PRESS_PEND: begin
            if (s2_q) begin
               if (cnt_q == CNT_LAST) begin
                  level_d = 1'b1;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         HELD, REL_PEND: begin
            if (!s2_q) begin
               if (cnt_q == CNT_LAST) begin
                  level_d   = 1'b0;
                  release_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q      <= btn_raw;
         s2_q      <= s1_q;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign press_next    = press_d;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/button_debounce_pulse.sv
// ============================================================================
//  button_debounce_pulse
//  N_BTN debounced buttons with press/release pulses and a merged press event.
//  Rev 1.0
// ============================================================================
`default_nettype none

module button_debounce_pulse
   import btn_pkg::*;
#(
   parameter int N_BTN         = DEFAULT_N_BTN,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic             any_press
);

   logic [N_BTN-1:0] press_next;
   logic             any_press_q, any_press_d;

   generate
      for (genvar g = 0; g < N_BTN; g++) begin : g_chan
         debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES)
         ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_raw       (btn_raw[g]),
            .btn_level     (btn_level[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .press_next    (press_next[g])
         );
      end
   endgenerate

   // OR the next-cycle terms so any_press lines up with press_pulse.
   assign any_press_d = |press_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_press_q <= 1'b0;
      end else begin
         any_press_q <= any_press_d;
      end
   end

   assign any_press = any_press_q;

endmodule : button_debounce_pulse

`default_nettype wire
